pe_tx_arbiter: RTL and testbench
================================

Name: pe_tx_arbiter

Overview:
- Shares one PE-to-router transmit port (tx / data_o / credit_i) between NUM_REQ local packet sources, e.g. DMA channels and CPU send queue.
- Grants are round-robin and wormhole: a granted requester owns the port from its header flit through its last payload flit.
- Packet format: flit0 = header, flit1 = payload size S in flits, then S payload flits.
- Sits between the PE's send engines and the PE-side port bundle toward the mesh.

Parameters:
- NUM_REQ, 4, number of requesters, 2..8.
- FLIT_WIDTH, 16, flit width in bits; the size field uses the full flit width.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- req_valid_i, input, NUM_REQ, requester k presents a valid flit.
- req_data_i, input, NUM_REQ*FLIT_WIDTH, flit of requester k at bits [k*FLIT_WIDTH +: FLIT_WIDTH].
- req_ready_o, output, NUM_REQ, flit of requester k consumed this cycle.
- tx, output, 1, flit valid toward router.
- data_o, output, FLIT_WIDTH, flit toward router.
- credit_i, input, 1, router can accept a flit this cycle.
- grant_o, output, NUM_REQ, one-hot current owner; all zero when idle.
- busy_o, output, 1, a packet is in progress.
- pkt_done_o, output, 1, one-cycle pulse on the last flit transfer of a packet.

Behaviour:
- Transfer rule: a flit moves when tx && credit_i.
  - tx = busy && req_valid_i[g], where g is the granted index.
  - data_o = req_data_i[g], a combinational mux.
  - req_ready_o[g] = busy && credit_i && req_valid_i[g]; all other ready bits are 0.
- Reset values:
  - Outputs: tx=0, req_ready_o=0, grant_o=0, busy_o=0, pkt_done_o=0, data_o=0 (data_o forced 0 while idle).
  - Internal: state=IDLE, last-grant pointer = NUM_REQ-1, so requester 0 wins first.
- State IDLE:
  - If any req_valid_i is high, register g = first set index searching cyclically from pointer+1, then go to HEADER. Arbitration costs one cycle: no transfer in the IDLE cycle.
  - If no req_valid_i is high, stay in IDLE.
- State HEADER: on transfer, go to SIZE.
- State SIZE:
  - On transfer, load cnt = data_o as an unsigned FLIT_WIDTH value.
  - If data_o == 0, the packet ends here: pulse pkt_done_o and go to IDLE.
  - Otherwise go to PAYLOAD.
- State PAYLOAD:
  - On each transfer, decrement cnt.
  - On the transfer with cnt == 1, pulse pkt_done_o and go to IDLE.
- Pointer update: the pointer is set to g when leaving for IDLE.
- Release timing: grant_o and busy_o drop in the cycle after the last transfer. Back-to-back packets therefore have a one-cycle IDLE gap.
- Mid-packet stalls:
  - credit_i low: hold state, tx may stay high, no transfer occurs.
  - Owner drops req_valid_i: tx goes low (bubble) and the grant is held. There is no timeout and no preemption.
- Non-owners see ready=0 regardless of their valid.
- Simultaneous events: requests arriving during a packet are evaluated at the next IDLE cycle only.
- Maximum size 2^FLIT_WIDTH-1 payload flits; cnt does not wrap.
- grant_o, busy_o, state and cnt are registered. tx, data_o and req_ready_o are combinational from registers, req_valid_i/req_data_i and credit_i.
- Reset asserted mid-packet: immediately return to reset values. The partially sent packet is abandoned; the router side is assumed reset together with the PE.

Optional Feature:
- Macro: PE_TX_ARB_STATS_EN.
- When defined, add two outputs:
  - pkt_count_o, 32 bits: increments on each pkt_done_o.
  - stall_count_o, 32 bits: increments each cycle busy && !(tx && credit_i).
- Both counters reset to 0 and wrap modulo 2^32.
- When undefined, both ports and all counter logic are absent.

Decomposition:
- Package pe_tx_arbiter_pkg holds:
  - typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} tx_arb_state_t;
  - constants HEADER_IDX=0 and SIZE_IDX=1.
- One sub-module, rr_pick: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot pick and binary index. It is reused by other PE arbiters.

Test Plan:
- Single packet: req0 sends header 0x0011, size 0x0003, payloads A,B,C, credit_i=1. Expect:
  - 5 consecutive tx cycles starting one cycle after valid;
  - pkt_done_o pulses with flit C;
  - grant_o=0001 during the packet, then 0000.
- Round-robin: req0..req3 all valid with 2-payload packets. Expect:
  - grant order 0,1,2,3,0;
  - each packet 4 flits;
  - one idle cycle between packets.
- Backpressure: credit_i toggles 1,0,0,1 during payload. Expect:
  - no flit lost or duplicated;
  - req_ready_o mirrors credit_i;
  - data_o stable while stalled.
- Zero size: size flit 0x0000. Expect pkt_done_o on the size flit and return to IDLE after exactly 2 transfers.
- Owner bubble and contention: req2 drops valid for 3 cycles mid-payload while req1 is valid. Expect:
  - tx=0 during the gap and grant held on req2;
  - req1 granted only after req2's last flit.
- Reset mid-packet: assert reset during PAYLOAD with cnt=5. Expect all outputs 0 immediately; after release, a request from req3 with req0 also valid is granted to req0 first. With PE_TX_ARB_STATS_EN defined, pkt_count_o=0.

Source files
------------

// File: rtl/pe_tx_arbiter_pkg.sv
// Shared types for the PE transmit arbiter: FSM state encoding and flit positions
// within a packet (header first, then the payload-size flit).
package pe_tx_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} tx_arb_state_t;

  localparam int HEADER_IDX = 0;
  localparam int SIZE_IDX   = 1;

endpackage

// File: rtl/pe_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after ptr (cyclically) wins.
// Zero latency; pick is all-zero when no request is present.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan from lowest to highest priority so the nearest request after ptr lands last.
  always_comb begin
    pick = '0;
    idx  = '0;
    cand = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(ptr) + i) % N);
      if (req[cand]) begin
        pick = N'(1) << cand;
        idx  = cand;
      end
    end
  end

endmodule

// File: rtl/pe_tx_arbiter.sv
// Round-robin wormhole arbiter sharing one PE transmit port between NUM_REQ sources.
// Optional PE_TX_ARB_STATS_EN adds packet and stall counters.
module pe_tx_arbiter
  import pe_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FLIT_WIDTH = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  input  logic [NUM_REQ*FLIT_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  output logic                            tx,
  output logic [FLIT_WIDTH-1:0]           data_o,
  input  logic                            credit_i,
  output logic [NUM_REQ-1:0]              grant_o,
  output logic                            busy_o,
  output logic                            pkt_done_o
`ifdef PE_TX_ARB_STATS_EN
  ,
  output logic [31:0]                     pkt_count_o,
  output logic [31:0]                     stall_count_o
`endif
);

  localparam int IW = $clog2(NUM_REQ);

  tx_arb_state_t         state;
  logic [IW-1:0]         gidx;
  logic [IW-1:0]         ptr;
  logic [FLIT_WIDTH-1:0] cnt;
  logic [NUM_REQ-1:0]    pick;
  logic [IW-1:0]         pick_idx;
  logic                  busy;
  logic                  xfer;
  logic                  last_flit;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req  (req_valid_i),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  assign busy        = (state != IDLE);
  assign busy_o      = busy;
  assign tx          = busy && req_valid_i[gidx];
  assign data_o      = busy ? req_data_i[gidx*FLIT_WIDTH +: FLIT_WIDTH] : '0;
  assign xfer        = tx && credit_i;
  assign req_ready_o = xfer ? grant_o : '0;

  // A zero size field closes the packet on the size flit itself.
  assign last_flit  = ((state == SIZE) && (data_o == '0)) ||
                      ((state == PAYLOAD) && (cnt == FLIT_WIDTH'(1)));
  assign pkt_done_o = xfer && last_flit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gidx    <= '0;
      ptr     <= IW'(NUM_REQ - 1);
      cnt     <= '0;
      grant_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid_i) begin
            gidx    <= pick_idx;
            grant_o <= pick;
            state   <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) state <= SIZE;
        end
        SIZE: begin
          if (xfer) begin
            cnt   <= data_o;
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (xfer) cnt <= cnt - FLIT_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
      // Closing the packet overrides the per-state next values above.
      if (pkt_done_o) begin
        state   <= IDLE;
        grant_o <= '0;
        ptr     <= gidx;
      end
    end
  end

`ifdef PE_TX_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_count_o   <= '0;
      stall_count_o <= '0;
    end else begin
      if (pkt_done_o)     pkt_count_o   <= pkt_count_o + 32'd1;
      if (busy && !xfer)  stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_tx_arbiter.sv
// Scoreboard bench for pe_tx_arbiter: directed packets are queued on source models,
// expected flits are pushed to a queue and a negedge monitor pops and compares.
module tb_pe_tx_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         done;
    logic [W-1:0] dat;
  } exp_t;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           tx;
  logic [W-1:0]   data;
  logic           credit = 1'b1;
  logic [N-1:0]   grant;
  logic           busy;
  logic           pkt_done;
`ifdef PE_TX_ARB_STATS_EN
  logic [31:0]    pkt_count;
  logic [31:0]    stall_count;
`endif

  pe_tx_arbiter #(.NUM_REQ(N), .FLIT_WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx          (tx),
    .data_o      (data),
    .credit_i    (credit),
    .grant_o     (grant),
    .busy_o      (busy),
    .pkt_done_o  (pkt_done)
`ifdef PE_TX_ARB_STATS_EN
    ,
    .pkt_count_o   (pkt_count),
    .stall_count_o (stall_count)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Source entries: bit 16 set marks a one-cycle bubble (valid low) token.
  logic [16:0] src_q[N][$];
  logic        cred_q[$];
  exp_t        exp_q[$];
  int          xt[$];
  int          busy_cyc, bub_cyc, stall_cyc;
  logic [N-1:0] tok_shown = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic clear_stats();
    xt.delete();
    busy_cyc  = 0;
    bub_cyc   = 0;
    stall_cyc = 0;
  endtask

  task automatic clear_queues();
    for (int k = 0; k < N; k++) src_q[k].delete();
    cred_q.delete();
    exp_q.delete();
  endtask

  task automatic load_pkt(input int k, input logic [W-1:0] hdr, input int n,
                          input logic [W-1:0] base, input int gap_at = -1, input int gap_len = 0);
    src_q[k].push_back({1'b0, hdr});
    src_q[k].push_back({1'b0, W'(n)});
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) for (int g = 0; g < gap_len; g++) src_q[k].push_back(17'h10000);
      src_q[k].push_back({1'b0, base + W'(i)});
    end
  endtask

  task automatic push_exp(input int k, input logic done, input logic [W-1:0] dat);
    exp_t e;
    e.gnt  = N'(1) << k;
    e.done = done;
    e.dat  = dat;
    exp_q.push_back(e);
  endtask

  task automatic expect_pkt(input int k, input logic [W-1:0] hdr, input int n, input logic [W-1:0] base);
    push_exp(k, 1'b0, hdr);
    push_exp(k, n == 0, W'(n));
    for (int i = 0; i < n; i++) push_exp(k, i == n - 1, base + W'(i));
  endtask

  task automatic wait_idle(input string name);
    int t;
    logic srcs_empty;
    for (t = 0; t < 400; t++) begin
      @(negedge clock);
      srcs_empty = 1'b1;
      for (int k = 0; k < N; k++) if (src_q[k].size() != 0) srcs_empty = 1'b0;
      if (exp_q.size() == 0 && srcs_empty && !busy) break;
    end
    check(name, t < 400, 1'b1);
    if (t >= 400) clear_queues();
  endtask

  task automatic check_times(input string name, input int base, input int offs[$]);
    check({name, "_count"}, xt.size(), offs.size());
    for (int i = 0; i < offs.size() && i < xt.size(); i++)
      check({name, "_cycle"}, xt[i], base + offs[i]);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #3 clear_queues();
    @(posedge clock);
    #3;
    @(negedge clock);
    #2 reset = 1'b0;
    clear_stats();
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Source and credit driver: consumes on ready, steps bubble tokens one per cycle.
  initial begin : driver
    logic [N-1:0] rdy;
    forever begin
      @(negedge clock);
      rdy = req_ready;
      @(posedge clock);
      #1;
      for (int k = 0; k < N; k++) begin
        if (src_q[k].size() > 0 && (rdy[k] || tok_shown[k])) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0 && !src_q[k][0][16]) begin
          req_valid[k]        = 1'b1;
          req_data[k*W +: W]  = src_q[k][0][W-1:0];
          tok_shown[k]        = 1'b0;
        end else begin
          req_valid[k] = 1'b0;
          tok_shown[k] = (src_q[k].size() > 0);
        end
      end
      credit = (cred_q.size() > 0) ? cred_q.pop_front() : 1'b1;
    end
  end

  initial begin : monitor
    logic [W-1:0] stall_dat;
    logic         was_stall;
    logic         prev_busy;
    logic [N-1:0] prev_gnt;
    exp_t         e;
    was_stall = 1'b0;
    prev_busy = 1'b0;
    prev_gnt  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        was_stall = 1'b0;
        prev_busy = 1'b0;
      end else begin
        if (busy) busy_cyc++;
        if (busy && !tx) bub_cyc++;
        if (tx && credit) begin
          xt.push_back(cyc);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_flit: got data %0h, expected no transfer", data);
          end else begin
            e = exp_q.pop_front();
            check("flit_data", data, e.dat);
            check("flit_done", pkt_done, e.done);
            check("flit_grant", grant, e.gnt);
            check("ready_on_xfer", req_ready, e.gnt);
          end
        end else begin
          check("ready_no_xfer", req_ready, 0);
          check("done_no_xfer", pkt_done, 0);
        end
        if (tx && !credit) begin
          stall_cyc++;
          if (was_stall) check("stall_data_stable", data, stall_dat);
          stall_dat = data;
          was_stall = 1'b1;
        end else begin
          was_stall = 1'b0;
        end
        if (busy && prev_busy) check("grant_held", grant, prev_gnt);
        if (!busy) check("idle_outputs", {tx, grant, data}, 0);
        prev_busy = busy;
        prev_gnt  = grant;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int L;
    int offs[$];

    repeat (2) @(negedge clock);
    check("reset_tx", tx, 0);
    check("reset_ready", req_ready, 0);
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_done", pkt_done, 0);
    check("reset_data", data, 0);
`ifdef PE_TX_ARB_STATS_EN
    check("reset_pkt_count", pkt_count, 0);
    check("reset_stall_count", stall_count, 0);
`endif
    #2 reset = 1'b0;

    // Single packet from requester 0.
    @(negedge clock);
    clear_stats();
    L = cyc;
    load_pkt(0, 16'h0011, 3, 16'h000A);
    expect_pkt(0, 16'h0011, 3, 16'h000A);
    wait_idle("single_complete");
    offs = '{2, 3, 4, 5, 6};
    check_times("single", L, offs);
    check("single_busy_cycles", busy_cyc, 5);
    check("single_grant_released", grant, 0);

    // Round-robin across all four, requester 0 carries a second packet.
    do_reset();
    @(negedge clock);
    L = cyc;
    for (int k = 0; k < N; k++) load_pkt(k, W'(16'h0100 * (k + 1)), 2, W'(16'h0010 + 16'h0100 * k));
    load_pkt(0, 16'h0500, 2, 16'h0510);
    for (int k = 0; k < N; k++) expect_pkt(k, W'(16'h0100 * (k + 1)), 2, W'(16'h0010 + 16'h0100 * k));
    expect_pkt(0, 16'h0500, 2, 16'h0510);
    wait_idle("rr_complete");
    offs.delete();
    for (int i = 0; i < 20; i++) offs.push_back(2 + (i / 4) * 5 + (i % 4));
    check_times("rr", L, offs);
    check("rr_busy_cycles", busy_cyc, 20);

    // Credit backpressure during payload.
    @(negedge clock);
    clear_stats();
    L = cyc;
    cred_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    load_pkt(1, 16'h1111, 3, 16'h00D1);
    expect_pkt(1, 16'h1111, 3, 16'h00D1);
    wait_idle("bp_complete");
    offs = '{2, 3, 4, 7, 8};
    check_times("bp", L, offs);
    check("bp_stall_cycles", stall_cyc, 2);

    // Zero-size packet.
    @(negedge clock);
    clear_stats();
    L = cyc;
    load_pkt(2, 16'h2222, 0, 16'h0000);
    expect_pkt(2, 16'h2222, 0, 16'h0000);
    wait_idle("zero_complete");
    offs = '{2, 3};
    check_times("zero", L, offs);
    check("zero_busy_cycles", busy_cyc, 2);

    // Owner bubble with a competing requester.
    @(negedge clock);
    clear_stats();
    L = cyc;
    load_pkt(2, 16'h2A00, 4, 16'h2A01, 2, 3);
    expect_pkt(2, 16'h2A00, 4, 16'h2A01);
    expect_pkt(1, 16'h1B00, 1, 16'h1B01);
    repeat (3) @(negedge clock);
    load_pkt(1, 16'h1B00, 1, 16'h1B01);
    wait_idle("bubble_complete");
    offs = '{2, 3, 4, 5, 9, 10, 12, 13, 14};
    check_times("bubble", L, offs);
    check("bubble_gap_cycles", bub_cyc, 3);
    check("bubble_busy_cycles", busy_cyc, 12);

    // Reset in the middle of a payload.
    do_reset();
    @(negedge clock);
    L = cyc;
    load_pkt(0, 16'h0C00, 5, 16'h0C01);
    push_exp(0, 1'b0, 16'h0C00);
    push_exp(0, 1'b0, 16'h0005);
    push_exp(0, 1'b0, 16'h0C01);
    repeat (4) @(negedge clock);
    check("midpkt_busy_before_reset", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("midpkt_reset_tx", tx, 0);
    check("midpkt_reset_ready", req_ready, 0);
    check("midpkt_reset_grant", grant, 0);
    check("midpkt_reset_busy", busy, 0);
    check("midpkt_reset_done", pkt_done, 0);
    check("midpkt_reset_data", data, 0);
`ifdef PE_TX_ARB_STATS_EN
    check("midpkt_reset_pkt_count", pkt_count, 0);
`endif
    check("midpkt_exp_drained", exp_q.size(), 0);
    @(posedge clock);
    #3 clear_queues();
    @(posedge clock);
    #3;
    @(negedge clock);
    #2 reset = 1'b0;
    clear_stats();
    @(negedge clock);
    L = cyc;
    load_pkt(3, 16'h3300, 1, 16'h3301);
    load_pkt(0, 16'h0D00, 1, 16'h0D01);
    expect_pkt(0, 16'h0D00, 1, 16'h0D01);
    expect_pkt(3, 16'h3300, 1, 16'h3301);
    wait_idle("post_reset_complete");
    offs = '{2, 3, 4, 6, 7, 8};
    check_times("post_reset", L, offs);
`ifdef PE_TX_ARB_STATS_EN
    check("post_reset_pkt_count", pkt_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
